led_stream_decoder: RTL and testbench



---
 rtl/led_stream_decoder_pkg.sv | 26 ++
 rtl/led_stream_decoder_if.sv | 34 +++
 rtl/led_stream_decoder_mac.sv | 26 ++
 rtl/led_stream_decoder.sv | 147 ++++++++++++++
 tb/tb_led_stream_decoder.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/led_stream_decoder_pkg.sv
// Shared definitions for the LED display digit link.
// Contents: default digit count, BCD digit type, largest legal digit,
//           decoder state encoding and the shift-add multiply-by-10 helper.
// Configuration macro used by the decoder: LED_DECODE_CHANGE_ONLY_EN.
package led_link_pkg;

  localparam int unsigned NUM_DIGITS_DEF = 8;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  typedef enum logic {
    HUNT,
    LOCK
  } dec_state_t;

  // Working width of mul10; callers truncate to their own width, which
  // gives the same result as doing the arithmetic mod 2^width.
  localparam int unsigned MAC_W = 64;

  function automatic logic [MAC_W-1:0] mul10(input logic [MAC_W-1:0] a);
    return (a << 3) + (a << 1);
  endfunction

endpackage

// File: rtl/led_stream_decoder_if.sv
// Digit-stream link plus decoded-result bundle for led_stream_decoder.
// Signals:
//   cclr_neg       frame marker, low on the cycle carrying the MSD
//   num            BCD digit, one per clock
//   balance        last good reconstructed value
//   balance_valid  one-cycle pulse, balance updated
//   locked         high once a frame marker has been seen
//   frame_err      one-cycle pulse, marker arrived mid-frame
//   digit_err      one-cycle pulse, completed frame had a digit > 9
// Modports: master drives the link and observes results; slave is the decoder.
interface led_stream_decoder_if #(
  parameter int unsigned OUT_W = 32
);
  import led_link_pkg::*;

  logic             cclr_neg;
  bcd_t             num;
  logic [OUT_W-1:0] balance;
  logic             balance_valid;
  logic             locked;
  logic             frame_err;
  logic             digit_err;

  modport master (
    output cclr_neg, num,
    input  balance, balance_valid, locked, frame_err, digit_err
  );

  modport slave (
    input  cclr_neg, num,
    output balance, balance_valid, locked, frame_err, digit_err
  );

endinterface

// File: rtl/led_stream_decoder_mac.sv
// bcd_mac_stage: combinational acc*10 + num, or num alone when load_i is set
// (frame start). Result is taken mod 2^OUT_W.
// Ports:
//   acc_i   running accumulator
//   num_i   incoming BCD digit
//   load_i  1 = start a new frame with num_i
//   acc_o   next accumulator value
module bcd_mac_stage
  import led_link_pkg::*;
#(
  parameter int unsigned OUT_W = 32
) (
  input  logic [OUT_W-1:0] acc_i,
  input  bcd_t             num_i,
  input  logic             load_i,
  output logic [OUT_W-1:0] acc_o
);

  always_comb begin
    acc_o = OUT_W'(num_i);
    if (!load_i) begin
      acc_o = OUT_W'(mul10(MAC_W'(acc_i))) + OUT_W'(num_i);
    end
  end

endmodule

// File: rtl/led_stream_decoder.sv
// led_stream_decoder: locks to the cclr_neg frame marker, captures NUM_DIGITS
// BCD digits MSD first, rebuilds the binary value and presents it with a
// one-cycle balance_valid pulse. All outputs are registered.
// Ports:
//   clk      system clock, rising edge
//   rst_neg  asynchronous active-low reset
//   bus      led_stream_decoder_if.slave (link inputs, result outputs)
// Optional feature macro: LED_DECODE_CHANGE_ONLY_EN -- when defined,
// balance_valid pulses only for the first good frame after reset or when a
// good frame's value differs from the stored balance.
module led_stream_decoder
  import led_link_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = NUM_DIGITS_DEF,
  parameter int unsigned OUT_W      = 32
) (
  input  logic                clk,
  input  logic                rst_neg,
  led_stream_decoder_if.slave bus
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  dec_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic             bad_q, bad_d;
  logic [OUT_W-1:0] balance_q, balance_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             ferr_q, ferr_d;
  logic             derr_q, derr_d;
`ifdef LED_DECODE_CHANGE_ONLY_EN
  logic             first_seen_q, first_seen_d;
`endif

  logic             load;
  logic             digit_bad;
  logic             bad_next;
  logic [OUT_W-1:0] mac_acc;

  bcd_mac_stage #(.OUT_W(OUT_W)) u_mac (
    .acc_i  (acc_q),
    .num_i  (bus.num),
    .load_i (load),
    .acc_o  (mac_acc)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    bad_d     = bad_q;
    balance_d = balance_q;
    valid_d   = 1'b0;
    locked_d  = locked_q;
    ferr_d    = 1'b0;
    derr_d    = 1'b0;
    load      = 1'b0;
`ifdef LED_DECODE_CHANGE_ONLY_EN
    first_seen_d = first_seen_q;
`endif
    digit_bad = (bus.num > BCD_MAX);
    bad_next  = bad_q | digit_bad;

    unique case (state_q)
      HUNT: begin
        if (!bus.cclr_neg) begin
          load     = 1'b1;
          acc_d    = mac_acc;
          idx_d    = IDX_W'(1);
          bad_d    = digit_bad;
          locked_d = 1'b1;
          state_d  = LOCK;
        end
      end
      LOCK: begin
        // idx 0 with no marker is the free-running wrap: a legal frame start.
        if (!bus.cclr_neg || idx_q == '0) begin
          load  = 1'b1;
          acc_d = mac_acc;
          idx_d = IDX_W'(1);
          bad_d = digit_bad;
          ferr_d = !bus.cclr_neg && (idx_q != '0);
        end else begin
          acc_d = mac_acc;
          bad_d = bad_next;
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (bad_next) begin
              derr_d = 1'b1;
            end else begin
              balance_d = mac_acc;
`ifdef LED_DECODE_CHANGE_ONLY_EN
              valid_d      = !first_seen_q || (mac_acc != balance_q);
              first_seen_d = 1'b1;
`else
              valid_d = 1'b1;
`endif
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_neg) begin
    if (!rst_neg) begin
      state_q   <= HUNT;
      idx_q     <= '0;
      acc_q     <= '0;
      bad_q     <= 1'b0;
      balance_q <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      ferr_q    <= 1'b0;
      derr_q    <= 1'b0;
`ifdef LED_DECODE_CHANGE_ONLY_EN
      first_seen_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      bad_q     <= bad_d;
      balance_q <= balance_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
      ferr_q    <= ferr_d;
      derr_q    <= derr_d;
`ifdef LED_DECODE_CHANGE_ONLY_EN
      first_seen_q <= first_seen_d;
`endif
    end
  end

  assign bus.balance       = balance_q;
  assign bus.balance_valid = valid_q;
  assign bus.locked        = locked_q;
  assign bus.frame_err     = ferr_q;
  assign bus.digit_err     = derr_q;

endmodule

// File: tb/tb_led_stream_decoder.sv
// Scoreboard bench for led_stream_decoder: stimulus pushes expected pulses
// (kind, value, cycle); a negedge monitor pops and compares every pulse.
module tb_led_stream_decoder;
  import led_link_pkg::*;

  typedef enum logic [1:0] {K_VALID, K_FERR, K_DERR} kind_t;

  typedef struct {
    kind_t       kind;
    logic [31:0] value;
    int          cyc;
    string       name;
  } exp_t;

  logic clk;
  logic rst_neg;
  int   checks;
  int   errors;
  int   cyc_cnt;
  exp_t sb[$];

  led_stream_decoder_if #(.OUT_W(32)) bus ();

  led_stream_decoder #(.NUM_DIGITS(8), .OUT_W(32)) dut (
    .clk     (clk),
    .rst_neg (rst_neg),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic push(input kind_t k, input logic [31:0] v, input string name);
    exp_t e;
    e.kind  = k;
    e.value = v;
    e.cyc   = cyc_cnt + 1;
    e.name  = name;
    sb.push_back(e);
  endtask

  task automatic check_ev(input kind_t k);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_pulse: actual kind=%0d balance=%0d at cycle %0d, required no pulse",
               k, bus.balance, cyc_cnt);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || e.cyc != cyc_cnt || (k != K_FERR && bus.balance !== e.value)) begin
        errors++;
        $display("FAIL %s: actual kind=%0d cycle=%0d balance=%0d, required kind=%0d cycle=%0d balance=%0d",
                 e.name, k, cyc_cnt, bus.balance, e.kind, e.cyc, e.value);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_neg) begin
      if (bus.balance_valid) check_ev(K_VALID);
      if (bus.frame_err)     check_ev(K_FERR);
      if (bus.digit_err)     check_ev(K_DERR);
    end
  end

  task automatic drive(input logic c, input logic [3:0] d);
    @(posedge clk);
    #1;
    bus.cclr_neg = c;
    bus.num      = d;
  endtask

  // Eight digits packed MSD first as hex nibbles; only the first may carry a marker.
  task automatic frame(input logic first_c, input logic [31:0] digits);
    logic [31:0] w;
    w = digits;
    for (int i = 0; i < 8; i++) begin
      drive((i == 0) ? first_c : 1'b1, w[31-4*i -: 4]);
    end
  endtask

  initial begin
    repeat (3000) @(posedge clk);
    $display("FAIL watchdog: actual timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks       = 0;
    errors       = 0;
    rst_neg      = 1'b0;
    bus.cclr_neg = 1'b1;
    bus.num      = 4'd0;
    repeat (2) @(posedge clk);
    #2;
    check_eq("reset_balance", 64'(bus.balance), 64'd0);
    check_eq("reset_valid", 64'(bus.balance_valid), 64'd0);
    check_eq("reset_locked", 64'(bus.locked), 64'd0);
    check_eq("reset_errs", 64'({bus.frame_err, bus.digit_err}), 64'd0);
    @(posedge clk);
    #1;
    rst_neg = 1'b1;
    drive(1'b1, 4'd3);
    drive(1'b1, 4'd3);
    check_eq("hunt_no_lock", 64'(bus.locked), 64'd0);

    // Marker frame 12345678
    drive(1'b0, 4'd1);
    drive(1'b1, 4'd2);
    check_eq("locked_after_marker", 64'(bus.locked), 64'd1);
    drive(1'b1, 4'd3); drive(1'b1, 4'd4); drive(1'b1, 4'd5);
    drive(1'b1, 4'd6); drive(1'b1, 4'd7); drive(1'b1, 4'd8);
    push(K_VALID, 32'd12345678, "frame_12345678");

    // Free-running wrap, back to back
    frame(1'b1, 32'h00000042);
    push(K_VALID, 32'd42, "wrap_42");

    // Marker at idx 3 aborts partial frame
    drive(1'b1, 4'd1); drive(1'b1, 4'd1); drive(1'b1, 4'd1);
    drive(1'b0, 4'd9);
    push(K_FERR, 32'd0, "ferr_idx3");
    for (int i = 0; i < 7; i++) drive(1'b1, 4'd9);
    push(K_VALID, 32'd99999999, "frame_99999999");

    // Illegal digit at idx 5
    frame(1'b1, 32'h12345C78);
    push(K_DERR, 32'd99999999, "digit_err_hold");
    frame(1'b1, 32'h00000007);
    push(K_VALID, 32'd7, "frame_7");

    // Marker coincident with completion digit
    for (int i = 0; i < 7; i++) drive(1'b1, 4'd1);
    drive(1'b0, 4'd2);
    push(K_FERR, 32'd0, "ferr_last_idx");
    drive(1'b1, 4'd0); drive(1'b1, 4'd0); drive(1'b1, 4'd0);
    drive(1'b1, 4'd0); drive(1'b1, 4'd0); drive(1'b1, 4'd0);
    drive(1'b1, 4'd3);
    push(K_VALID, 32'd20000003, "frame_20000003");

    // Asynchronous reset mid-frame at idx 4
    drive(1'b1, 4'd1); drive(1'b1, 4'd2); drive(1'b1, 4'd3); drive(1'b1, 4'd4);
    @(posedge clk);
    #3;
    rst_neg = 1'b0;
    #1;
    check_eq("async_rst_balance", 64'(bus.balance), 64'd0);
    check_eq("async_rst_locked", 64'(bus.locked), 64'd0);
    check_eq("async_rst_pulses",
             64'({bus.balance_valid, bus.frame_err, bus.digit_err}), 64'd0);
    @(posedge clk);
    #1;
    rst_neg = 1'b1;
    for (int i = 0; i < 8; i++) drive(1'b1, 4'd5);
    check_eq("post_rst_hunt", 64'(bus.locked), 64'd0);
    check_eq("post_rst_balance", 64'(bus.balance), 64'd0);

    // Identical frames
    frame(1'b0, 32'h00000555);
    push(K_VALID, 32'd555, "frame_555_first");
    frame(1'b0, 32'h00000555);
`ifndef LED_DECODE_CHANGE_ONLY_EN
    push(K_VALID, 32'd555, "frame_555_second");
`endif
    drive(1'b1, 4'd0); drive(1'b1, 4'd0); drive(1'b1, 4'd0);
    @(negedge clk);
    check_eq("scoreboard_drained", 64'(sb.size()), 64'd0);
    check_eq("final_balance", 64'(bus.balance), 64'd555);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
